clk_div_prog: RTL and testbench

//  Runtime-programmable clock-enable/divider generator; next generation of the fixed time_divided divider.

---
 rtl/clk_div_prog.sv | 148 ++++++++++++++
 tb/tb_clk_div_prog.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable clock divider with tick strobe and boundary-synchronous reload
// Optional period counter output enabled by defining CLKDIV_PERIOD_CNT_EN.
module clk_div_prog #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             clkout,
  output logic             tick,
  output logic             load_pend,
  output logic [DIV_W-1:0] div_act
`ifdef CLKDIV_PERIOD_CNT_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nx;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] w_act_nx;
  logic [DIV_W-1:0] r_pend_div;
  logic [DIV_W-1:0] w_pdiv_nx;
  logic             r_load_pend;
  logic             w_pend_nx;
  logic             r_clkout;
  logic             w_clk_nx;
  logic             r_tick;
  logic             w_tick_nx;
  logic             w_last;
  logic [DIV_W-1:0] w_cnt_inc;
  logic [DIV_W-1:0] w_next_div;

  // High phase is the first ceil(N/2) counts; extra bit keeps N+1 from overflowing.
  function automatic logic level(input logic [DIV_W-1:0] n, input logic [DIV_W-1:0] c);
    logic [DIV_W:0] hi;
    hi = ({1'b0, n} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    return ({1'b0, c} < hi);
  endfunction

  assign w_last     = (r_cnt == (r_div_act - 1'b1));
  assign w_cnt_inc  = r_cnt + 1'b1;
  // Divisor for the period about to start: a same-cycle load beats an older pending one.
  assign w_next_div = div_load ? div_val : (r_load_pend ? r_pend_div : r_div_act);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_act_nx   = r_div_act;
    w_pdiv_nx  = r_pend_div;
    w_pend_nx  = r_load_pend;
    w_clk_nx   = 1'b0;
    w_tick_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nx  = '0;
        w_pend_nx = 1'b0;
        if (div_load) w_act_nx = div_val;
        if (en && (r_div_act != '0)) begin
          w_state_nx = RUN;
          w_tick_nx  = 1'b1;
          w_clk_nx   = 1'b1;
        end
      end
      RUN: begin
        if (!en || (r_div_act == '0)) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
          w_pend_nx  = 1'b0;
          w_act_nx   = w_next_div;
        end else if (w_last) begin
          w_cnt_nx  = '0;
          w_pend_nx = 1'b0;
          w_act_nx  = w_next_div;
          // A zero divisor applied here starts no period; the next edge idles.
          w_tick_nx = (w_next_div != '0);
          w_clk_nx  = level(w_next_div, '0);
        end else begin
          w_cnt_nx = w_cnt_inc;
          w_clk_nx = level(r_div_act, w_cnt_inc);
          if (div_load) begin
            w_pdiv_nx = div_val;
            w_pend_nx = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_div_act   <= DEF_DIV;
      r_pend_div  <= '0;
      r_load_pend <= 1'b0;
      r_clkout    <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_div_act   <= w_act_nx;
      r_pend_div  <= w_pdiv_nx;
      r_load_pend <= w_pend_nx;
      r_clkout    <= w_clk_nx;
      r_tick      <= w_tick_nx;
    end
  end

`ifdef CLKDIV_PERIOD_CNT_EN
  logic [31:0] r_period_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_period_cnt <= '0;
    end else if (w_state_nx == IDLE) begin
      r_period_cnt <= '0;
    end else if (w_tick_nx) begin
      r_period_cnt <= r_period_cnt + 32'd1;
    end
  end

  assign period_cnt = r_period_cnt;
`endif

  assign clkout    = r_clkout;
  assign tick      = r_tick;
  assign load_pend = r_load_pend;
  assign div_act   = r_div_act;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - table-driven self-checking bench for clk_div_prog
module tb_clk_div_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div_val;
  logic        div_load;
  logic        clkout;
  logic        tick;
  logic        load_pend;
  logic [15:0] div_act;
`ifdef CLKDIV_PERIOD_CNT_EN
  logic [31:0] period_cnt;
`endif

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.DIV_W(16), .DEFAULT_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_val   (div_val),
    .div_load  (div_load),
    .clkout    (clkout),
    .tick      (tick),
    .load_pend (load_pend),
    .div_act   (div_act)
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [15:0] dv;
    logic        ld;
    logic        clkout;
    logic        tick;
    logic        pend;
    logic [15:0] act;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic [15:0] dv, input logic l,
                              input logic c, input logic t, input logic p, input logic [15:0] a);
    vec_t v;
    v.rst = r; v.en = e; v.dv = dv; v.ld = l;
    v.clkout = c; v.tick = t; v.pend = p; v.act = a;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, input logic e, input logic [15:0] dv, input logic l);
    @(negedge clk);
    rst = r; en = e; div_val = dv; div_load = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic c, input logic t, input logic p, input logic [15:0] a);
    checks++;
    if (clkout !== c || tick !== t || load_pend !== p || div_act !== a) begin
      errors++;
      $display("FAIL %s: got clkout=%0b tick=%0b load_pend=%0b div_act=%0d, want clkout=%0b tick=%0b load_pend=%0b div_act=%0d",
               name, clkout, tick, load_pend, div_act, c, t, p, a);
    end
  endtask

  initial begin
    int ticks;
    int lat;
    rst = 1'b0; en = 1'b0; div_val = '0; div_load = 1'b0;

    // reset hold with en and load active
    for (int i = 0; i < 3; i++) add(0, 1, 16'd7, 1, 0, 0, 0, 16'd2);
    // default N=2
    add(1, 1, 0, 0, 1, 1, 0, 16'd2);
    add(1, 1, 0, 0, 0, 0, 0, 16'd2);
    add(1, 1, 0, 0, 1, 1, 0, 16'd2);
    add(1, 1, 0, 0, 0, 0, 0, 16'd2);
    add(1, 0, 0, 0, 0, 0, 0, 16'd2);
    // odd N=5 loaded while idle
    add(1, 0, 16'd5, 1, 0, 0, 0, 16'd5);
    for (int k = 0; k < 2; k++) begin
      add(1, 1, 0, 0, 1, 1, 0, 16'd5);
      add(1, 1, 0, 0, 1, 0, 0, 16'd5);
      add(1, 1, 0, 0, 1, 0, 0, 16'd5);
      add(1, 1, 0, 0, 0, 0, 0, 16'd5);
      add(1, 1, 0, 0, 0, 0, 0, 16'd5);
    end
    add(1, 0, 0, 0, 0, 0, 0, 16'd5);
    // N=4, load N=6 on the edge to cnt=1
    add(1, 0, 16'd4, 1, 0, 0, 0, 16'd4);
    add(1, 1, 0, 0, 1, 1, 0, 16'd4);
    add(1, 1, 16'd6, 1, 1, 0, 1, 16'd4);
    add(1, 1, 0, 0, 0, 0, 1, 16'd4);
    add(1, 1, 0, 0, 0, 0, 1, 16'd4);
    for (int k = 0; k < 2; k++) begin
      add(1, 1, 0, 0, 1, 1, 0, 16'd6);
      add(1, 1, 0, 0, 1, 0, 0, 16'd6);
      add(1, 1, 0, 0, 1, 0, 0, 16'd6);
      add(1, 1, 0, 0, 0, 0, 0, 16'd6);
      add(1, 1, 0, 0, 0, 0, 0, 16'd6);
      add(1, 1, 0, 0, 0, 0, 0, 16'd6);
    end
    add(1, 0, 0, 0, 0, 0, 0, 16'd6);
    // N=1, then N=0 loaded in the wrap cycle
    add(1, 0, 16'd1, 1, 0, 0, 0, 16'd1);
    for (int k = 0; k < 4; k++) add(1, 1, 0, 0, 1, 1, 0, 16'd1);
    add(1, 1, 16'd0, 1, 0, 0, 0, 16'd0);
    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, 0, 0, 16'd0);
    // N=8 abort at cnt=3, restart, then reset mid-period
    add(1, 0, 16'd8, 1, 0, 0, 0, 16'd8);
    add(1, 1, 0, 0, 1, 1, 0, 16'd8);
    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 1, 0, 0, 16'd8);
    add(1, 0, 0, 0, 0, 0, 0, 16'd8);
    add(1, 1, 0, 0, 1, 1, 0, 16'd8);
    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 1, 0, 0, 16'd8);
    add(0, 1, 0, 0, 0, 0, 0, 16'd2);
    add(1, 1, 0, 0, 1, 1, 0, 16'd2);
    add(1, 1, 0, 0, 0, 0, 0, 16'd2);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].dv, vecs[i].ld);
      check($sformatf("vec%0d", i), vecs[i].clkout, vecs[i].tick, vecs[i].pend, vecs[i].act);
    end

    // overwrite while pending: last write (5) wins at the N=8 boundary
    step(1, 0, 16'd8, 1);
    check("ovr_idle_load", 0, 0, 0, 16'd8);
    step(1, 1, 0, 0);
    step(1, 1, 16'd3, 1);
    check("ovr_first", 1, 0, 1, 16'd8);
    step(1, 1, 16'd5, 1);
    check("ovr_second", 1, 0, 1, 16'd8);
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0);
    check("ovr_last_cnt", 0, 0, 1, 16'd8);
    step(1, 1, 0, 0);
    check("ovr_apply", 1, 1, 0, 16'd5);
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 0, 0);
      if (tick) ticks++;
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL ovr_tick_count: got %0d ticks, want 2", ticks);
    end

    // start latency with a bounded wait
    step(1, 0, 0, 0);
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      step(1, 1, 0, 0);
      if (tick) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL start_latency: got %0d cycles (0 = timeout), want 1", lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
